// File: rtl/ddr_wr_burst_pkg.sv
// Shared constants, state encoding and sizing helper for the DDR write-burst path.
package ddr_wr_burst_pkg;

    localparam int DDR_W       = 64;
    localparam int DDR_BYTES   = DDR_W / 8;
    localparam int BURST_LEN_W = 5;

    // Bits needed to index n entries, never less than 1.
    function automatic int bw(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CMD,
        ST_DATA
    } wr_state_e;

endpackage

// File: rtl/ddr_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags and an occupancy count.
module ddr_wr_fifo
    import ddr_wr_burst_pkg::*;
#(
    parameter int  DATA_W = DDR_W,
    parameter int  DEPTH  = 32,
    localparam int PTR_W  = bw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign cnt_nxt  = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= cnt_nxt;
            full  <= (cnt_nxt == (PTR_W+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr_wr_burst.sv
// Buffers the result stream and issues it to DDR as command + data bursts, tracking write responses.
module ddr_wr_burst
    import ddr_wr_burst_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int BURST_MAX  = 16,
    parameter int ADDR_W     = 32,
    parameter int OUTS_MAX   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   done,
    input  logic [ADDR_W-1:0]      conf_base_addr,
    input  logic [15:0]            conf_beat_num,
    input  logic [BURST_LEN_W-1:0] conf_burst_len,
    input  logic [DDR_W-1:0]       s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [ADDR_W-1:0]      cmd_addr,
    output logic [7:0]             cmd_len,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [DDR_W-1:0]       wr_data,
    output logic                   wr_last,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    input  logic                   wr_resp_valid
);

    localparam int CNT_W  = bw(FIFO_DEPTH) + 1;
    localparam int OUTS_W = bw(OUTS_MAX + 1);

    function automatic logic [BURST_LEN_W-1:0] clip_burst(input logic [BURST_LEN_W-1:0] len);
        if (len == '0) return BURST_LEN_W'(1);
        if (int'(len) > BURST_MAX) return BURST_LEN_W'(BURST_MAX);
        return len;
    endfunction

    wr_state_e              state;
    wr_state_e              state_nxt;
    logic                   done_r;
    logic [BURST_LEN_W-1:0] burst_len_r;
    logic [BURST_LEN_W-1:0] cur_len;
    logic [BURST_LEN_W-1:0] cur_len_r;
    logic [BURST_LEN_W-1:0] beat_cnt;
    logic [15:0]            rem_in;
    logic [15:0]            rem_cmd;
    logic [ADDR_W-1:0]      addr;
    logic [OUTS_W-1:0]      outs_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   start_acc;
    logic                   push;
    logic                   pop;
    logic                   cmd_acc;
    logic                   last_beat;
    logic                   resp_dec;

    ddr_wr_fifo #(
        .DATA_W (DDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .pop_data  (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // done is high exactly while the FSM sits in IDLE, so it doubles as the start gate.
    assign start_acc = start && done_r;
    assign done      = done_r;
    assign push      = s_valid && s_ready;
    assign cur_len   = (rem_cmd < 16'(burst_len_r)) ? rem_cmd[BURST_LEN_W-1:0] : burst_len_r;
    assign last_beat = (beat_cnt == cur_len_r - BURST_LEN_W'(1));
    assign cmd_acc   = (state == ST_CMD) && cmd_ready;
    assign pop       = (state == ST_DATA) && wr_ready && !fifo_empty;
    assign resp_dec  = wr_resp_valid && ((outs_cnt != '0) || cmd_acc);

    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        s_ready   = !fifo_full && (rem_in != '0) && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start_acc) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A burst is only commanded once every one of its beats is already buffered.
                if ((rem_cmd != '0) && (outs_cnt < OUTS_W'(OUTS_MAX)) &&
                    (16'(fifo_count) >= 16'(cur_len)))
                    state_nxt = ST_CMD;
                else if ((rem_cmd == '0) && (outs_cnt == '0))
                    state_nxt = ST_IDLE;
            end
            ST_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = addr;
                cmd_len   = 8'(cur_len_r - BURST_LEN_W'(1));
                if (cmd_ready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                wr_valid = 1'b1;
                wr_last  = last_beat;
                if (wr_ready && !fifo_empty && last_beat) state_nxt = ST_WAIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            done_r   <= 1'b1;
            rem_in   <= '0;
            rem_cmd  <= '0;
            outs_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state  <= state_nxt;
            done_r <= (state_nxt == ST_IDLE);
            if (start_acc) begin
                rem_in   <= conf_beat_num;
                rem_cmd  <= conf_beat_num;
                outs_cnt <= '0;
            end else begin
                if (push)    rem_in  <= rem_in - 16'd1;
                if (cmd_acc) rem_cmd <= rem_cmd - 16'(cur_len_r);
                if (cmd_acc && !resp_dec)
                    outs_cnt <= outs_cnt + OUTS_W'(1);
                else if (!cmd_acc && resp_dec)
                    outs_cnt <= outs_cnt - OUTS_W'(1);
            end
            if (cmd_acc)
                beat_cnt <= '0;
            else if (pop)
                beat_cnt <= beat_cnt + BURST_LEN_W'(1);
        end
    end

    // Address and length registers hold data only; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            addr        <= conf_base_addr;
            burst_len_r <= clip_burst(conf_burst_len);
        end else if (cmd_acc) begin
            addr <= addr + ADDR_W'(cur_len_r) * ADDR_W'(DDR_BYTES);
        end
        if (state == ST_WAIT) cur_len_r <= cur_len;
    end

endmodule

// File: tb/tb_ddr_wr_burst.sv
// Directed and randomized bench for ddr_wr_burst, checked against a burst-list and data-queue model.
module tb_ddr_wr_burst;
    import ddr_wr_burst_pkg::*;

    localparam int FD = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             done;
    logic [31:0]      conf_base_addr;
    logic [15:0]      conf_beat_num;
    logic [4:0]       conf_burst_len;
    logic [DDR_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      cmd_addr;
    logic [7:0]       cmd_len;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DDR_W-1:0] wr_data;
    logic             wr_last;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_resp_valid;

    always #5 clk = ~clk;

    ddr_wr_burst #(
        .FIFO_DEPTH (FD),
        .BURST_MAX  (16),
        .ADDR_W     (32),
        .OUTS_MAX   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .conf_base_addr (conf_base_addr),
        .conf_beat_num  (conf_beat_num),
        .conf_burst_len (conf_burst_len),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_resp_valid  (wr_resp_valid)
    );

    int checks = 0;
    int failures = 0;

    logic [39:0]      exp_cmd[$];
    logic [DDR_W-1:0] exp_data[$];
    int tile_n, exp_nb, pushed, popped, resps_given, pending_resp, cmds_seen, burst_left;
    bit tile_on, saw_full, force_resp;
    int in_mode, wr_mode, cmd_delay, resp_mode, cmd_wait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference burst list: split the tile into min(burst_len, remaining)-beat bursts.
    task automatic build_model(input logic [31:0] base, input int n, input int bl);
        int ble, rem, len;
        logic [31:0] a;
        ble = (bl == 0) ? 1 : ((bl > 16) ? 16 : bl);
        exp_cmd.delete();
        exp_data.delete();
        rem = n;
        a = base;
        exp_nb = 0;
        while (rem > 0) begin
            len = (rem < ble) ? rem : ble;
            exp_cmd.push_back({a, 8'(len - 1)});
            a = a + 32'(len * DDR_BYTES);
            rem = rem - len;
            exp_nb++;
        end
    endtask

    task automatic clear_model();
        exp_cmd.delete();
        exp_data.delete();
        tile_on = 1'b0;
        tile_n = 0;
        exp_nb = 0;
        pushed = 0;
        popped = 0;
        resps_given = 0;
        pending_resp = 0;
        cmds_seen = 0;
        burst_left = 0;
        saw_full = 1'b0;
    endtask

    task automatic cycle();
        bit in_fire, c_fire, w_fire;
        logic exp_sr;
        logic [39:0] e;
        @(negedge clk);
        exp_sr = tile_on && ((pushed - popped) < FD) && (pushed < tile_n);
        chk("s_ready", 64'(s_ready), 64'(exp_sr));
        if (pushed - popped == FD) saw_full = 1'b1;
        if (burst_left > 0) chk("wr_valid_hold", 64'(wr_valid), 64'd1);
        if (tile_on && (resps_given < exp_nb)) chk("done_low", 64'(done), 64'd0);
        in_fire = s_valid && s_ready;
        c_fire  = cmd_valid && cmd_ready;
        w_fire  = wr_valid && wr_ready;
        if (w_fire) begin
            if (burst_left == 0 || exp_data.size() == 0) begin
                chk("wr_outside_burst", 64'(wr_valid), 64'd0);
            end else begin
                chk("wr_data", wr_data, exp_data.pop_front());
                chk("wr_last", 64'(wr_last), 64'(burst_left == 1));
                if (burst_left == 1) pending_resp++;
                burst_left--;
                popped++;
            end
        end
        if (c_fire) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_extra", 64'(cmd_valid), 64'd0);
            end else begin
                e = exp_cmd.pop_front();
                chk("cmd_addr", 64'(cmd_addr), 64'(e[39:8]));
                chk("cmd_len", 64'(cmd_len), 64'(e[7:0]));
                burst_left = int'(e[7:0]) + 1;
            end
            cmds_seen++;
        end
        if (in_fire) begin
            exp_data.push_back(s_data);
            pushed++;
        end
        @(posedge clk);
        #1;
        if (in_fire) s_data = {$urandom, $urandom};
        s_valid  = (in_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        wr_ready = (wr_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        if (cmd_valid) cmd_wait++; else cmd_wait = 0;
        cmd_ready = (cmd_wait >= cmd_delay);
        wr_resp_valid = 1'b0;
        if (pending_resp > 0) begin
            if (force_resp) begin
                wr_resp_valid = 1'b1;
                force_resp = 1'b0;
            end else if (resp_mode == 1) begin
                wr_resp_valid = 1'b1;
            end else if (resp_mode == 2 && $urandom_range(0, 2) == 0) begin
                wr_resp_valid = 1'b1;
            end
        end
        if (wr_resp_valid) begin
            pending_resp--;
            resps_given++;
        end
    endtask

    task automatic start_tile(input logic [31:0] base, input int n, input int bl);
        clear_model();
        build_model(base, n, bl);
        tile_n = n;
        conf_base_addr = base;
        conf_beat_num  = 16'(n);
        conf_burst_len = 5'(bl);
        start = 1'b1;
        cycle();
        start = 1'b0;
        tile_on = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        chk("done_rise", 64'(done), 64'd1);
        chk("cmds_left", 64'(exp_cmd.size()), 64'd0);
        chk("data_left", 64'(exp_data.size()), 64'd0);
        chk("resps", 64'(resps_given), 64'(exp_nb));
        tile_on = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        conf_base_addr = '0;
        conf_beat_num = '0;
        conf_burst_len = '0;
        s_data = {$urandom, $urandom};
        s_valid = 1'b0;
        cmd_ready = 1'b1;
        wr_ready = 1'b1;
        wr_resp_valid = 1'b0;
        force_resp = 1'b0;
        in_mode = 0; wr_mode = 0; cmd_delay = 0; resp_mode = 1; cmd_wait = 0;
        clear_model();

        repeat (3) cycle();
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_last", 64'(wr_last), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst_cmd_len", 64'(cmd_len), 64'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // Two full 16-beat bursts, everything ready.
        start_tile(32'h1000, 32, 16);
        wait_done(400);
        chk("t1_cmds", 64'(cmds_seen), 64'd2);

        // Tail burst, random write back-pressure, and a start that must be ignored mid-tile.
        wr_mode = 1;
        start_tile(32'h1000, 20, 8);
        repeat (6) cycle();
        conf_base_addr = 32'hDEAD_0000;
        conf_beat_num  = 16'd3;
        conf_burst_len = 5'd1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(600);
        chk("t2_cmds", 64'(cmds_seen), 64'd3);

        // Delayed commands, random responses, burst length clipped to the maximum, FIFO fills.
        cmd_delay = 5;
        resp_mode = 2;
        start_tile(32'h5000, 64, 20);
        wait_done(2000);
        chk("t3_cmds", 64'(cmds_seen), 64'd4);
        chk("t3_fifo_full_seen", 64'(saw_full), 64'd1);

        // Response window: the fifth burst waits for a response slot.
        wr_mode = 0;
        cmd_delay = 0;
        resp_mode = 0;
        start_tile(32'h8000, 80, 16);
        k = 0;
        while (!(cmds_seen == 4 && burst_left == 0) && k < 400) begin
            cycle();
            k++;
        end
        chk("t4_four_cmds", 64'(cmds_seen), 64'd4);
        repeat (20) cycle();
        chk("t4_blocked_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("t4_blocked_cmds", 64'(cmds_seen), 64'd4);
        chk("t4_blocked_done", 64'(done), 64'd0);
        force_resp = 1'b1;
        k = 0;
        while (cmds_seen < 5 && k < 6) begin
            cycle();
            k++;
        end
        chk("t4_fifth_cmd", 64'(cmds_seen), 64'd5);
        resp_mode = 1;
        wait_done(400);

        // Empty tile: done drops for one cycle only, and a start in that cycle is dropped.
        start_tile(32'h2000, 0, 4);
        chk("t5_done_drop", 64'(done), 64'd0);
        conf_beat_num = 16'd8;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t5_done_back", 64'(done), 64'd1);
        repeat (10) cycle();
        chk("t5_done_stays", 64'(done), 64'd1);
        chk("t5_no_cmd", 64'(cmds_seen), 64'd0);
        tile_on = 1'b0;

        // Reset in the middle of a burst, then a clean tile afterwards.
        start_tile(32'h3000, 32, 16);
        k = 0;
        while (popped < 5 && k < 200) begin
            cycle();
            k++;
        end
        chk("t6_mid_burst", 64'(burst_left > 0), 64'd1);
        rst = 1'b1;
        cycle();
        chk("t6_rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("t6_rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("t6_rst_s_ready", 64'(s_ready), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd1);
        clear_model();
        rst = 1'b0;
        repeat (2) cycle();
        start_tile(32'h4000, 32, 16);
        wait_done(400);
        chk("t6_after_cmds", 64'(cmds_seen), 64'd2);

        // Zero burst length means single-beat bursts; address wraps modulo 2^32.
        wr_mode = 1;
        start_tile(32'hFFFF_FFF0, 3, 0);
        wait_done(200);
        chk("t7_cmds", 64'(cmds_seen), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
